// File: rtl/serial_tx.sv
// serial_tx: LSB-first framed serializer; even parity bit inserted when SERIAL_TX_PARITY_EN is defined
module serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out,
    output logic             busy
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CLAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DLAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] SLAST = BW'(STOP_BITS - 1);
`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam state_t AFTER_DATA = PARITY;
    logic par;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam state_t AFTER_DATA = STOP;
`endif
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [BW-1:0] bitcnt, bit_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic out_n, bit_end;

    assign in_ready = state == IDLE;
    assign busy = state != IDLE;

    always_comb begin
        bit_end = cnt == CLAST;
        state_n = state;
        bit_n = bitcnt;
        shreg_n = shreg;
        cnt_n = (state == IDLE || bit_end) ? '0 : cnt + CW'(1);
        case (state)
            IDLE: if (in_valid) begin
                state_n = START;
                bit_n = '0;
                shreg_n = in_data;
            end
            START: if (bit_end) state_n = DATA;
            DATA: if (bit_end) begin
                if (bitcnt == DLAST) begin
                    state_n = AFTER_DATA;
                    bit_n = '0;
                end else begin
                    bit_n = bitcnt + BW'(1);
                    shreg_n = shreg >> 1;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: if (bit_end) state_n = STOP;
`endif
            STOP: if (bit_end) begin
                if (bitcnt == SLAST) state_n = IDLE;
                else bit_n = bitcnt + BW'(1);
            end
            default: state_n = IDLE;
        endcase
        // out is registered, so it is derived from the state being entered
`ifdef SERIAL_TX_PARITY_EN
        out_n = state_n == START ? 1'b0 : state_n == DATA ? shreg_n[0] : state_n == PARITY ? par : 1'b1;
`else
        out_n = state_n == START ? 1'b0 : state_n == DATA ? shreg_n[0] : 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            bitcnt <= '0;
            shreg <= '0;
            out <= 1'b1;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            bitcnt <= bit_n;
            shreg <= shreg_n;
            out <= out_n;
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) par <= 1'b0;
        else if (in_ready && in_valid) par <= ^in_data;
    end
`endif
endmodule
